// File: rtl/rx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rx_pkg
// Description : Shared types and constants for the receive-buffer read path.
// Revision    : 1.0 - initial release
// ============================================================================
package rx_pkg;

   // Byte width of the receive buffer and of the outgoing stream.
   localparam int RX_DATA_W = 8;

   // Default message length; the buffer sizes its message slots from this too.
   localparam int RX_MSG_BYTES = 64;

   // Read-side sequencer states.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2
   } rx_drain_state_t;

endpackage : rx_pkg
`default_nettype wire

// File: rtl/rx_out_fifo2.sv
`default_nettype none
// ============================================================================
// Module      : rx_out_fifo2
// Description : Two-entry byte FIFO that decouples buffer read latency from
//               stream backpressure. Simultaneous push and pop is allowed.
// Revision    : 1.0 - initial release
// ============================================================================
module rx_out_fifo2
   import rx_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 push,
   input  logic [RX_DATA_W-1:0] push_data,
   input  logic                 pop,
   output logic [RX_DATA_W-1:0] head_data,
   output logic [1:0]           count
);

   logic [RX_DATA_W-1:0] r_mem [0:1];
   logic                 r_wr_ptr;
   logic                 r_rd_ptr;
   logic [1:0]           r_count;
   logic                 w_do_push;
   logic                 w_do_pop;

   // A push into a full FIFO only lands if the head leaves in the same cycle.
   always_comb begin
      w_do_pop  = pop && (r_count != 2'd0);
      w_do_push = push && ((r_count != 2'd2) || w_do_pop);
   end

   // Storage, pointers and occupancy.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
            r_wr_ptr        <= ~r_wr_ptr;
         end
         if (w_do_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         r_count <= r_count + {1'b0, w_do_push} - {1'b0, w_do_pop};
      end
   end

   assign head_data = r_mem[r_rd_ptr];
   assign count     = r_count;

endmodule : rx_out_fifo2
`default_nettype wire

// File: rtl/rx_drain_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rx_drain_ctrl
// Description : Drains one fixed-length message from the receive buffer and
//               presents it as an AXI-Stream byte message with tlast on the
//               final byte, hiding the buffer's registered read latency.
// Revision    : 1.0 - initial release
// ============================================================================
module rx_drain_ctrl
   import rx_pkg::*;
#(
   parameter int MSG_BYTES = RX_MSG_BYTES,
   parameter int CNT_W     = $clog2(MSG_BYTES + 1),
   parameter int MSGCNT_W  = 16
)
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   output logic                 busy,
   output logic                 done,
   input  logic                 brx_empty,
   output logic                 brx_rd_en,
   input  logic [RX_DATA_W-1:0] rx_data,
   output logic [RX_DATA_W-1:0] m_tdata,
   output logic                 m_tvalid,
   input  logic                 m_tready,
   output logic                 m_tlast,
   output logic [MSGCNT_W-1:0]  msg_count
);

   localparam logic [CNT_W-1:0] C_MSG_BYTES = CNT_W'(MSG_BYTES);
   localparam logic [CNT_W-1:0] C_LAST_IDX  = CNT_W'(MSG_BYTES - 1);

   rx_drain_state_t      r_state;
   rx_drain_state_t      w_state_nxt;
   logic [CNT_W-1:0]     r_issued;
   logic [CNT_W-1:0]     r_sent;
   logic                 r_inflight;
   logic [MSGCNT_W-1:0]  r_msg_count;
   logic [1:0]           w_q_count;
   logic [2:0]           w_occupancy;
   logic                 w_room;
   logic                 w_pop;
   logic                 w_accept;
   logic                 w_start_msg;

   // Queue slots already spoken for: stored bytes plus the one in flight.
   // Comparing against 2+pop avoids an underflowing subtraction.
   always_comb begin
      w_pop       = m_tvalid && m_tready;
      w_occupancy = {1'b0, w_q_count} + {2'b00, r_inflight};
      w_room      = w_occupancy < (3'd2 + {2'b00, w_pop});
      w_accept    = brx_rd_en && !brx_empty;
      w_start_msg = (r_state == IDLE) && start;
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state, read issue and completion strobe.
   always_comb begin
      w_state_nxt = r_state;
      busy        = 1'b0;
      brx_rd_en   = 1'b0;
      done        = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_state_nxt = READ;
            end
         end
         READ: begin
            busy      = 1'b1;
            brx_rd_en = (r_issued < C_MSG_BYTES) && w_room;
            if (r_issued == C_MSG_BYTES) begin
               w_state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            busy = 1'b1;
            if (w_pop && (r_sent == C_LAST_IDX)) begin
               done        = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Issued/sent byte counters, restarted when a new message begins.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_issued <= '0;
         r_sent   <= '0;
      end else if (w_start_msg) begin
         r_issued <= '0;
         r_sent   <= '0;
      end else begin
         if (w_accept) begin
            r_issued <= r_issued + 1'b1;
         end
         if (w_pop) begin
            r_sent <= r_sent + 1'b1;
         end
      end
   end

   // Marks that the buffer will present read data on the next cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_inflight <= 1'b0;
      end else begin
         r_inflight <= w_accept;
      end
   end

   // Completed-message counter, free-running modulo its width.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_msg_count <= '0;
      end else if (done) begin
         r_msg_count <= r_msg_count + 1'b1;
      end
   end

   rx_out_fifo2 u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (r_inflight),
      .push_data (rx_data),
      .pop       (w_pop),
      .head_data (m_tdata),
      .count     (w_q_count)
   );

   assign m_tvalid  = (w_q_count != 2'd0);
   assign m_tlast   = m_tvalid && (r_sent == C_LAST_IDX);
   assign msg_count = r_msg_count;

endmodule : rx_drain_ctrl
`default_nettype wire

// File: tb/tb_rx_drain_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_rx_drain_ctrl
// Description : Scoreboard bench for rx_drain_ctrl with an 8-byte message and
//               a behavioural receive buffer with one-cycle read latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rx_drain_ctrl;

   localparam int MB = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        busy, done;
   logic        brx_empty, brx_rd_en;
   logic [7:0]  rx_data = 8'h00;
   logic [7:0]  m_tdata;
   logic        m_tvalid, m_tready, m_tlast;
   logic [15:0] msg_count;

   // Second instance with a 2-bit message counter so its wrap is reachable.
   logic        start2;
   logic        busy2, done2, rd2, tvalid2, tlast2;
   logic [7:0]  rx2 = 8'h00;
   logic [7:0]  tdata2;
   logic [1:0]  msg2;

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;
   int beats_seen = 0;
   int done_cnt = 0;
   int acc_cyc = -1;
   int val_cyc = -1;
   logic lat_arm = 1'b0;
   logic prev_stall = 1'b0;
   logic [7:0] prev_data = 8'h00;
   logic [8:0] exp_q [$];

   logic [7:0] buf_mem [0:255];
   int wr_idx = 0;
   int rd_idx = 0;

   always #5 clk = ~clk;

   rx_drain_ctrl #(.MSG_BYTES(MB)) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
      .brx_empty(brx_empty), .brx_rd_en(brx_rd_en), .rx_data(rx_data),
      .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
      .m_tlast(m_tlast), .msg_count(msg_count)
   );

   rx_drain_ctrl #(.MSG_BYTES(2), .MSGCNT_W(2)) u_wrap (
      .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2),
      .brx_empty(1'b0), .brx_rd_en(rd2), .rx_data(rx2),
      .m_tdata(tdata2), .m_tvalid(tvalid2), .m_tready(1'b1),
      .m_tlast(tlast2), .msg_count(msg2)
   );

   // Receive buffer model: registered read data, empty when indices meet.
   assign brx_empty = (rd_idx == wr_idx);
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (brx_rd_en && !brx_empty) begin
         rx_data <= buf_mem[rd_idx[7:0]];
         rd_idx  <= rd_idx + 1;
      end
      if (rd2) rx2 <= rx2 + 8'd1;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push_exp(input int base);
      for (int i = 0; i < MB; i++) begin
         exp_q.push_back({(i == MB - 1), buf_mem[(base + i) % 256]});
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      for (int i = 0; i < budget; i++) begin
         if (!busy) return;
         tick();
      end
      n_vec++;
      n_err++;
      $display("FAIL wait_idle: busy still 1 after %0d cycles, required 0", budget);
   endtask

   // Monitor: pops the scoreboard on every handshake and watches stall rules.
   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (lat_arm) begin
            if (brx_rd_en && !brx_empty && acc_cyc < 0) acc_cyc = cyc;
            if (m_tvalid && val_cyc < 0) val_cyc = cyc;
         end
         if (prev_stall) begin
            chk("stall_hold", {m_tvalid, m_tdata}, {1'b1, prev_data});
         end
         if (dut.w_q_count > 2'd2) begin
            chk("q_count_le_2", 64'(dut.w_q_count), 64'd2);
         end
         if (m_tvalid && m_tready) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL extra_beat: got %0h, required no beat", m_tdata);
            end else begin
               logic [8:0] e;
               e = exp_q.pop_front();
               chk("beat", {m_tlast, m_tdata}, e);
               chk("done_with_last", done, e[8]);
            end
            beats_seen++;
         end
         if (done) done_cnt++;
         prev_stall = m_tvalid && !m_tready;
         prev_data  = m_tdata;
      end
   end

   initial begin
      int base;
      int d0;
      logic pat [4];
      pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
      for (int i = 0; i < 256; i++) buf_mem[i] = 8'(i);
      rst = 1'b1; start = 1'b0; start2 = 1'b0; m_tready = 1'b1;
      repeat (3) tick();
      chk("reset_state", {busy, done, brx_rd_en, m_tvalid, m_tlast, m_tdata, msg_count}, 64'd0);
      rst = 1'b0;
      tick();

      // Basic message, always ready, with latency checks.
      wr_idx += MB;
      push_exp(rd_idx);
      lat_arm = 1'b1;
      pulse_start();
      chk("first_rd_en", brx_rd_en, 1'b1);
      wait_idle(100);
      lat_arm = 1'b0;
      chk("valid_latency", 64'(val_cyc - acc_cyc), 64'd2);
      chk("msg_count_1", msg_count, 16'd1);
      chk("done_cnt_1", 64'(done_cnt), 64'd1);

      // Backpressure pattern 1,0,0,1.
      wr_idx += MB;
      push_exp(rd_idx);
      pulse_start();
      for (int k = 0; k < 200 && busy; k++) begin
         m_tready = pat[k % 4];
         tick();
      end
      m_tready = 1'b1;
      wait_idle(20);
      chk("msg_count_2", msg_count, 16'd2);

      // Buffer runs dry after 3 bytes; the rest arrive 10 cycles later.
      base = rd_idx;
      wr_idx += 3;
      push_exp(base);
      pulse_start();
      repeat (9) tick();
      chk("dry_stall", {busy, m_tvalid}, 2'b10);
      chk("dry_reads", 64'(rd_idx - base), 64'd3);
      wr_idx += 5;
      wait_idle(100);
      chk("msg_count_3", msg_count, 16'd3);

      // start held high across two messages.
      d0 = done_cnt;
      wr_idx += 2 * MB;
      push_exp(rd_idx);
      push_exp(rd_idx + MB);
      start = 1'b1;
      for (int k = 0; k < 300 && done_cnt < d0 + 2; k++) tick();
      start = 1'b0;
      wait_idle(20);
      repeat (4) tick();
      chk("two_msgs_done", 64'(done_cnt - d0), 64'd2);
      chk("two_msgs_idle", busy, 1'b0);
      chk("msg_count_5", msg_count, 16'd5);

      // Reset in the middle of a message.
      d0 = beats_seen;
      wr_idx += 2 * MB;
      push_exp(rd_idx);
      pulse_start();
      for (int k = 0; k < 100 && beats_seen < d0 + 4; k++) tick();
      m_tready = 1'b0;
      rst = 1'b1;
      exp_q.delete();
      tick();
      chk("mid_reset", {busy, done, brx_rd_en, m_tvalid, m_tlast, m_tdata, msg_count}, 64'd0);
      chk("mid_reset_state", 64'(dut.r_state), 64'd0);
      rst = 1'b0;
      m_tready = 1'b1;
      tick();
      push_exp(rd_idx);
      pulse_start();
      wait_idle(100);
      chk("msg_count_after_rst", msg_count, 16'd1);

      // Message counter wrap on the narrow-counter instance.
      for (int m = 0; m < 4; m++) begin
         start2 = 1'b1;
         tick();
         start2 = 1'b0;
         for (int k = 0; k < 50 && busy2; k++) tick();
         if (m == 2) chk("wrap_max", msg2, 2'd3);
      end
      chk("wrap_zero", msg2, 2'd0);

      repeat (3) tick();
      chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_rx_drain_ctrl
`default_nettype wire
